dual_fifo_bridge: RTL

DUAL_FIFO_BRIDGE -- requirements
Module: dual_fifo_bridge

---
 rtl/bridge_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 50 +++++
 rtl/dual_fifo_bridge.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared types for dual_fifo_bridge: FSM state encodings, the statistics counter width
// and the packed debug view that exposes every FSM state and FIFO occupancy.
package bridge_pkg;

    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_HOLD = 1'b1
    } in_state_e;

    typedef enum logic [1:0] {
        OUT_IDLE  = 2'd0,
        OUT_REQ   = 2'd1,
        OUT_DRAIN = 2'd2
    } out_state_e;

    localparam int c_STATW = 16;

    // Occupancy fields are 8 bits, enough for depth powers up to 7.
    typedef struct packed {
        in_state_e  ab_in;
        out_state_e b_out;
        in_state_e  ba_in;
        out_state_e a_out;
        logic       loopback;
        logic [7:0] ab_count;
        logic [7:0] ba_count;
    } bridge_dbg_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extended (depth-power + 1 bit) pointers; write and pop in the
// same cycle always both succeed, with a bypass path when the FIFO is empty.
module sync_fifo #(
    parameter int c_DEPTHPOW2 = 4,
    parameter int c_WIDTH     = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_write,
    input  logic [c_WIDTH-1:0]   i_wdata,
    input  logic                 i_pop,
    output logic [c_WIDTH-1:0]   o_rdata,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [c_DEPTHPOW2:0] o_count
);

    localparam int c_DEPTH = 2 ** c_DEPTHPOW2;

    logic [c_WIDTH-1:0]   mem [c_DEPTH];
    logic [c_DEPTHPOW2:0] wptr;
    logic [c_DEPTHPOW2:0] rptr;
    logic                 do_write;
    logic                 do_pop;

    assign o_empty  = (wptr == rptr);
    assign o_full   = (wptr[c_DEPTHPOW2] != rptr[c_DEPTHPOW2]) &&
                      (wptr[c_DEPTHPOW2-1:0] == rptr[c_DEPTHPOW2-1:0]);
    assign o_count  = wptr - rptr;
    assign do_pop   = i_pop && (!o_empty || i_write);
    assign do_write = i_write && (!o_full || do_pop);
    assign o_rdata  = o_empty ? i_wdata : mem[rptr[c_DEPTHPOW2-1:0]];

    always_ff @(posedge i_clock) begin
        if (do_write) begin
            mem[wptr[c_DEPTHPOW2-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_write) wptr <= wptr + 1'b1;
            if (do_pop)   rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/dual_fifo_bridge.sv
// Two independent byte paths (A->B, B->A): intake FSM -> sync_fifo -> output FSM, plus A loopback.
// Defining BRIDGE_STATS_EN adds 16-bit completed-byte counters o_abcount (B sink) and o_bacount (A sink).
module dual_fifo_bridge
    import bridge_pkg::*;
#(
    parameter int c_ABDEPTHPOW2 = 4,
    parameter int c_BADEPTHPOW2 = 3,
    parameter int c_NEARFULL    = 2,
    parameter int c_ACKTIMEOUT  = 255
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_aavail,
    input  logic [7:0]        i_adata,
    output logic              o_aread,
    output logic [7:0]        o_adata,
    output logic              o_aenable,
    input  logic              i_abusy,
    input  logic              i_bavail,
    input  logic [7:0]        i_bdata,
    output logic              o_bread,
    output logic [7:0]        o_bdata,
    output logic              o_benable,
    input  logic              i_bbusy,
    input  logic              i_loopback,
    output logic              o_abnearfull,
    output logic              o_abfull,
    output logic              o_err,
`ifdef BRIDGE_STATS_EN
    output logic [c_STATW-1:0] o_abcount,
    output logic [c_STATW-1:0] o_bacount,
`endif
    output bridge_dbg_t       o_dbgstate
);

    // Handshakes: a source byte is taken on the edge the intake leaves IDLE with avail=1, and
    // read then stays high until avail=0 is seen. A sink gets stable data with enable=1,
    // acknowledges by raising busy (enable drops), and busy=0 again completes the byte.

    localparam int              c_ABDEPTH = 2 ** c_ABDEPTHPOW2;
    localparam int              c_TW      = $clog2(c_ACKTIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TLAST   = c_TW'(c_ACKTIMEOUT - 1);

    in_state_e  ab_in_q, ba_in_q;
    out_state_e a_out_q, b_out_q;
    logic       ab_wr_q, ba_wr_q;
    logic [7:0] ab_wdata_q, ba_wdata_q;
    logic [7:0] ab_rdata, ba_rdata;
    logic       ab_full, ab_empty, ba_full, ba_empty;
    logic       ab_pop, ba_pop, a_pop, b_pop;
    logic [c_ABDEPTHPOW2:0] ab_count;
    logic [c_BADEPTHPOW2:0] ba_count;
    logic [c_TW-1:0] a_timer, b_timer;
    logic       a_tmo, b_tmo;
    logic       loop_q;
    logic       a_src_empty;
    logic [7:0] a_src_data;

    // The captured byte lands in the FIFO one edge after capture; the intake is in HOLD then.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ab_in_q    <= IN_IDLE;
            o_aread    <= 1'b0;
            ab_wr_q    <= 1'b0;
            ab_wdata_q <= '0;
        end else begin
            ab_wr_q <= 1'b0;
            case (ab_in_q)
                IN_IDLE: if (i_aavail && !ab_full) begin
                    ab_wr_q    <= 1'b1;
                    ab_wdata_q <= i_adata;
                    o_aread    <= 1'b1;
                    ab_in_q    <= IN_HOLD;
                end
                IN_HOLD: if (!i_aavail) begin
                    o_aread <= 1'b0;
                    ab_in_q <= IN_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ba_in_q    <= IN_IDLE;
            o_bread    <= 1'b0;
            ba_wr_q    <= 1'b0;
            ba_wdata_q <= '0;
        end else begin
            ba_wr_q <= 1'b0;
            case (ba_in_q)
                IN_IDLE: if (i_bavail && !ba_full) begin
                    ba_wr_q    <= 1'b1;
                    ba_wdata_q <= i_bdata;
                    o_bread    <= 1'b1;
                    ba_in_q    <= IN_HOLD;
                end
                IN_HOLD: if (!i_bavail) begin
                    o_bread <= 1'b0;
                    ba_in_q <= IN_IDLE;
                end
            endcase
        end
    end

    sync_fifo #(.c_DEPTHPOW2(c_ABDEPTHPOW2), .c_WIDTH(8)) u_ab_fifo (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .i_write  (ab_wr_q),
        .i_wdata  (ab_wdata_q),
        .i_pop    (ab_pop),
        .o_rdata  (ab_rdata),
        .o_full   (ab_full),
        .o_empty  (ab_empty),
        .o_count  (ab_count)
    );

    sync_fifo #(.c_DEPTHPOW2(c_BADEPTHPOW2), .c_WIDTH(8)) u_ba_fifo (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .i_write  (ba_wr_q),
        .i_wdata  (ba_wdata_q),
        .i_pop    (ba_pop),
        .o_rdata  (ba_rdata),
        .o_full   (ba_full),
        .o_empty  (ba_empty),
        .o_count  (ba_count)
    );

    assign o_abfull     = ab_full;
    assign o_abnearfull = (c_ABDEPTH - int'(ab_count)) <= c_NEARFULL;

    // Loopback only switches while both sinks are idle so no transfer changes source midway.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            loop_q <= 1'b0;
        end else if (a_out_q == OUT_IDLE && b_out_q == OUT_IDLE) begin
            loop_q <= i_loopback;
        end
    end

    assign a_src_empty = loop_q ? ab_empty : ba_empty;
    assign a_src_data  = loop_q ? ab_rdata : ba_rdata;
    assign a_pop       = (a_out_q == OUT_IDLE) && !a_src_empty && !i_abusy;
    assign b_pop       = (b_out_q == OUT_IDLE) && !loop_q && !ab_empty && !i_bbusy;
    assign ab_pop      = loop_q ? a_pop : b_pop;
    assign ba_pop      = !loop_q && a_pop;
    assign a_tmo       = (a_out_q == OUT_REQ) && !i_abusy && (a_timer == c_TLAST);
    assign b_tmo       = (b_out_q == OUT_REQ) && !i_bbusy && (b_timer == c_TLAST);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            a_out_q   <= OUT_IDLE;
            o_aenable <= 1'b0;
            o_adata   <= '0;
            a_timer   <= '0;
        end else begin
            case (a_out_q)
                OUT_IDLE: if (a_pop) begin
                    o_adata   <= a_src_data;
                    o_aenable <= 1'b1;
                    a_timer   <= '0;
                    a_out_q   <= OUT_REQ;
                end
                OUT_REQ: begin
                    if (i_abusy) begin
                        o_aenable <= 1'b0;
                        a_out_q   <= OUT_DRAIN;
                    end else if (a_tmo) begin
                        o_aenable <= 1'b0;
                        a_out_q   <= OUT_IDLE;
                    end else begin
                        a_timer <= a_timer + 1'b1;
                    end
                end
                OUT_DRAIN: if (!i_abusy) a_out_q <= OUT_IDLE;
                default: begin
                    o_aenable <= 1'b0;
                    a_out_q   <= OUT_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            b_out_q   <= OUT_IDLE;
            o_benable <= 1'b0;
            o_bdata   <= '0;
            b_timer   <= '0;
        end else begin
            case (b_out_q)
                OUT_IDLE: if (b_pop) begin
                    o_bdata   <= ab_rdata;
                    o_benable <= 1'b1;
                    b_timer   <= '0;
                    b_out_q   <= OUT_REQ;
                end
                OUT_REQ: begin
                    if (i_bbusy) begin
                        o_benable <= 1'b0;
                        b_out_q   <= OUT_DRAIN;
                    end else if (b_tmo) begin
                        o_benable <= 1'b0;
                        b_out_q   <= OUT_IDLE;
                    end else begin
                        b_timer <= b_timer + 1'b1;
                    end
                end
                OUT_DRAIN: if (!i_bbusy) b_out_q <= OUT_IDLE;
                default: begin
                    o_benable <= 1'b0;
                    b_out_q   <= OUT_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_err <= 1'b0;
        end else if (a_tmo || b_tmo) begin
            o_err <= 1'b1;
        end
    end

`ifdef BRIDGE_STATS_EN
    logic a_done, b_done;
    assign a_done = (a_out_q == OUT_DRAIN) && !i_abusy;
    assign b_done = (b_out_q == OUT_DRAIN) && !i_bbusy;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_abcount <= '0;
            o_bacount <= '0;
        end else begin
            if (b_done) o_abcount <= o_abcount + 1'b1;
            if (a_done) o_bacount <= o_bacount + 1'b1;
        end
    end
`endif

    always_comb begin
        o_dbgstate          = '0;
        o_dbgstate.ab_in    = ab_in_q;
        o_dbgstate.b_out    = b_out_q;
        o_dbgstate.ba_in    = ba_in_q;
        o_dbgstate.a_out    = a_out_q;
        o_dbgstate.loopback = loop_q;
        o_dbgstate.ab_count = 8'(ab_count);
        o_dbgstate.ba_count = 8'(ba_count);
    end

endmodule
